board_input_controller: RTL
===========================

// Module: board_input_controller
// PURPOSE
//  Owns the 64-square board state and the cursor/selection registers read by the VGA renderer.
//  Debounces five raw push-buttons, moves the cursor and runs a select/move FSM.
//  Commits piece moves into BOARD with no legality checking beyond turn colour.
//  Sits in top between the board pads and display_interface.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000  consecutive stable cycles before a button change is accepted (10 ms @ 50 MHz)
//  CURSOR_INIT      52      cursor reset square {row,col} = {6,4}
// PORTS
//  CLK          in   1    system clock; all state on posedge CLK
//  RESET        in   1    asynchronous, active-low reset
//  BTN_UP       in   1    raw button, asynchronous, active-high
//  BTN_DOWN     in   1    raw button
//  BTN_LEFT     in   1    raw button
//  BTN_RIGHT    in   1    raw button
//  BTN_CENTER   in   1    raw button: select / deselect / move
//  BOARD        out  256  square i = BOARD[4i+3:4i]; [2:0] piece, [3] colour (1 = black)
//  CURSOR_ADDR  out  6    {row[2:0],col[2:0]}; row 0 = top
//  SELECT_ADDR  out  6    selected source square
//  SELECT_EN    out  1    SELECT_ADDR valid
//  TURN         out  1    colour to move (0 = white)
//  MOVE_DONE    out  1    one-cycle strobe when a move is committed
//  GAME_OVER    out  1    latched when a king is captured
// BEHAVIOUR
//  Reset values:
//   - BOARD = standard start position. Row 0 = black R,N,B,Q,K,B,N,R; row 1 = black pawns;
//     rows 2-5 = 0; row 6 = white pawns; row 7 = white back rank.
//   - Piece codes: NONE 0, PAWN 1, KNIGHT 2, BISHOP 3, ROOK 4, QUEEN 5, KING 6.
//   - CURSOR_ADDR = CURSOR_INIT; SELECT_ADDR = 0; SELECT_EN = 0; TURN = 0; MOVE_DONE = 0; GAME_OVER = 0.
//  Debounce, per button:
//   - 2-flop synchroniser, then counter. Counter resets whenever the sample equals the debounced state.
//   - Debounced state flips after DEBOUNCE_CYCLES consecutive differing samples.
//   - Debounced rising edge gives a 1-cycle press pulse. Holding a button gives exactly one pulse; no auto-repeat.
//  Cursor:
//   - UP: row-1; DOWN: row+1; LEFT: col-1; RIGHT: col+1.
//   - Saturates at the board edges; no wrap.
//   - Same-cycle direction pulses: priority UP > DOWN > LEFT > RIGHT; only one is applied.
//   - Cursor movement is active in every FSM state and after GAME_OVER.
//  FSM states: IDLE, SELECTED, COMMIT. Let sq = BOARD square at pre-update CURSOR_ADDR.
//   - IDLE + center: if sq.piece != 0 and sq.colour == TURN, then SELECT_ADDR <= cursor,
//     SELECT_EN <= 1, go to SELECTED. Otherwise ignore.
//   - SELECTED + center, cursor == SELECT_ADDR: SELECT_EN <= 0, go to IDLE (deselect).
//   - SELECTED + center, sq is own colour: SELECT_ADDR <= cursor (reselect), stay in SELECTED.
//   - SELECTED + center, sq empty or opponent: latch dst <= cursor, go to COMMIT.
//   - COMMIT (exactly one cycle), in the same edge:
//     - BOARD[dst] <= BOARD[SELECT_ADDR]; BOARD[SELECT_ADDR] <= 0.
//     - TURN toggles; SELECT_EN <= 0; MOVE_DONE <= 1 for one cycle.
//     - GAME_OVER <= 1 if old BOARD[dst].piece == KING.
//     - Next state IDLE.
//   - Latency: center pulse in cycle N gives state COMMIT in N+1; BOARD, TURN and MOVE_DONE are visible in N+2.
//   - Center pulses during COMMIT are dropped.
//   - Center and direction pulses in the same cycle: center uses the pre-move cursor, and the cursor still moves.
//   - GAME_OVER = 1: all center pulses ignored and FSM held in IDLE until RESET.
//  Reset asserted mid-operation: every register returns asynchronously to its reset value.
//   A COMMIT in flight is abandoned and the board reverts to the start position.
// STRUCTURE
//  chess_pkg.vh: piece codes, COLOR_WHITE/BLACK, square-index macro, initial-board constant.
//   Shared with display_interface.
//  Sub-module btn_debounce (sync + counter + edge pulse), instantiated 5x.
//  FSM, cursor and board registers live in this module.
// TESTING (DEBOUNCE_CYCLES = 4)
//  1 Reset: BOARD[3:0] = 4'hC (black rook), square 60 = 4'h6, CURSOR_ADDR = 52, TURN = 0, SELECT_EN = 0.
//  2 BTN_UP glitch 2 cycles -> no cursor change; held 10 cycles -> CURSOR_ADDR = 44 exactly once.
//  3 Cursor at 0, press UP then LEFT -> stays 0. At 63, press DOWN then RIGHT -> stays 63.
//  4 Select 52 (white pawn), cursor UP x2 to 36, center -> square 36 = 4'h1, square 52 = 0,
//    TURN = 1, one MOVE_DONE pulse 2 cycles after the center pulse.
//  5 TURN = 0, center on black pawn 12 -> SELECT_EN stays 0. Select 52, center on 52 again -> SELECT_EN = 0.
//  6 Place a white queen via moves, capture the square-4 black king -> GAME_OVER = 1;
//    further center presses leave BOARD unchanged; async RESET mid-COMMIT restores the start board.

Source files
------------

// File: rtl/board_input_controller_pkg.sv
// ---------------------------------------------------------------------------
// board_input_controller_pkg
//   Shared chess definitions for the board input controller and the display
//   side: piece codes, colour constants, square addressing helpers, the
//   select/move FSM state type and the standard starting position.
//   No ports (package).
// ---------------------------------------------------------------------------
package board_input_controller_pkg;

  typedef enum logic [2:0] {
    PIECE_NONE   = 3'd0,
    PIECE_PAWN   = 3'd1,
    PIECE_KNIGHT = 3'd2,
    PIECE_BISHOP = 3'd3,
    PIECE_ROOK   = 3'd4,
    PIECE_QUEEN  = 3'd5,
    PIECE_KING   = 3'd6
  } piece_e;

  localparam logic COLOR_WHITE = 1'b0;
  localparam logic COLOR_BLACK = 1'b1;

  // One board square as stored in the 4-bit BOARD nibble.
  typedef struct packed {
    logic   colour;
    piece_e piece;
  } square_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SELECTED = 2'd1,
    ST_COMMIT   = 2'd2
  } ctrl_state_e;

  // Starting position. Square 0 is the least significant nibble, so each
  // 32-bit group below reads square 7..0 of a row from left to right.
  // Row 0 (black back rank) is the last group, row 7 (white) the first.
  localparam logic [255:0] INIT_BOARD = {
    32'h4236_5324,   // row 7: white R N B Q K B N R
    32'h1111_1111,   // row 6: white pawns
    32'h0000_0000,   // row 5
    32'h0000_0000,   // row 4
    32'h0000_0000,   // row 3
    32'h0000_0000,   // row 2
    32'h9999_9999,   // row 1: black pawns
    32'hCABE_DBAC    // row 0: black R N B Q K B N R
  };

  // Square address is {row, col}, row 0 at the top of the screen.
  function automatic logic [5:0] sq_index(input logic [2:0] row, input logic [2:0] col);
    return {row, col};
  endfunction

  function automatic square_t get_square(input logic [255:0] board, input logic [5:0] idx);
    return square_t'(board[{idx, 2'b00} +: 4]);
  endfunction

endpackage

// File: rtl/board_input_controller_btn_debounce.sv
// ---------------------------------------------------------------------------
// board_input_controller_btn_debounce
//   Debounces one raw asynchronous push-button and emits a single-cycle
//   press pulse on the debounced rising edge.
//   Ports:
//     CLK    in  1  system clock
//     RESET  in  1  asynchronous, active-low reset
//     btn    in  1  raw button, active-high, asynchronous to CLK
//     press  out 1  one-cycle pulse when the debounced state goes 0 -> 1
// ---------------------------------------------------------------------------
module board_input_controller_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic btn,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             hit;

  // The current differing sample is the last one needed to accept the change.
  assign hit = (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  // Synchroniser, stability counter and press pulse. The counter only runs
  // while the synchronised sample disagrees with the accepted state, so any
  // bounce back to the accepted level restarts the count from zero. The
  // press pulse is only raised on an accepted 0 -> 1 change, so a held
  // button produces exactly one pulse.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      stable  <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
      press   <= 1'b0;
      if (sync_q2 == stable) begin
        cnt <= '0;
      end else if (hit) begin
        stable <= sync_q2;
        cnt    <= '0;
        press  <= sync_q2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/board_input_controller.sv
// ---------------------------------------------------------------------------
// board_input_controller
//   Owns the 64-square board and the cursor/selection registers read by the
//   VGA renderer. Debounces five buttons, moves the cursor, and runs a
//   select/move FSM that commits moves with only a turn-colour check.
//   Ports:
//     CLK          in  1    system clock
//     RESET        in  1    asynchronous, active-low reset
//     BTN_UP       in  1    raw button, cursor row - 1
//     BTN_DOWN     in  1    raw button, cursor row + 1
//     BTN_LEFT     in  1    raw button, cursor col - 1
//     BTN_RIGHT    in  1    raw button, cursor col + 1
//     BTN_CENTER   in  1    raw button, select / deselect / move
//     BOARD        out 256  square i = BOARD[4i+3:4i]; [2:0] piece, [3] colour
//     CURSOR_ADDR  out 6    {row, col}, row 0 = top
//     SELECT_ADDR  out 6    selected source square
//     SELECT_EN    out 1    SELECT_ADDR valid
//     TURN         out 1    colour to move (0 = white)
//     MOVE_DONE    out 1    one-cycle strobe when a move is committed
//     GAME_OVER    out 1    latched when a king is captured
// ---------------------------------------------------------------------------
module board_input_controller
  import board_input_controller_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = 500000,
  parameter logic [5:0] CURSOR_INIT     = 6'd52
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         BTN_UP,
  input  logic         BTN_DOWN,
  input  logic         BTN_LEFT,
  input  logic         BTN_RIGHT,
  input  logic         BTN_CENTER,
  output logic [255:0] BOARD,
  output logic [5:0]   CURSOR_ADDR,
  output logic [5:0]   SELECT_ADDR,
  output logic         SELECT_EN,
  output logic         TURN,
  output logic         MOVE_DONE,
  output logic         GAME_OVER
);

  logic press_up;
  logic press_down;
  logic press_left;
  logic press_right;
  logic press_center;

  ctrl_state_e state;
  ctrl_state_e state_next;

  logic [5:0] dst_addr;
  logic [5:0] cursor_next;
  logic [2:0] cur_row;
  logic [2:0] cur_col;

  square_t    cur_sq;
  logic       cur_own;
  logic       load_sel;
  logic       clear_sel;
  logic       latch_dst;
  logic       do_commit;

  board_input_controller_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .CLK(CLK), .RESET(RESET), .btn(BTN_UP), .press(press_up)
  );
  board_input_controller_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .CLK(CLK), .RESET(RESET), .btn(BTN_DOWN), .press(press_down)
  );
  board_input_controller_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .CLK(CLK), .RESET(RESET), .btn(BTN_LEFT), .press(press_left)
  );
  board_input_controller_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .CLK(CLK), .RESET(RESET), .btn(BTN_RIGHT), .press(press_right)
  );
  board_input_controller_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_center (
    .CLK(CLK), .RESET(RESET), .btn(BTN_CENTER), .press(press_center)
  );

  assign cur_row = CURSOR_ADDR[5:3];
  assign cur_col = CURSOR_ADDR[2:0];

  // Cursor step. Only the highest-priority direction pulse is considered,
  // even when that one is blocked by the board edge.
  always_comb begin
    cursor_next = CURSOR_ADDR;
    if (press_up) begin
      if (cur_row != 3'd0) cursor_next = sq_index(cur_row - 3'd1, cur_col);
    end else if (press_down) begin
      if (cur_row != 3'd7) cursor_next = sq_index(cur_row + 3'd1, cur_col);
    end else if (press_left) begin
      if (cur_col != 3'd0) cursor_next = sq_index(cur_row, cur_col - 3'd1);
    end else if (press_right) begin
      if (cur_col != 3'd7) cursor_next = sq_index(cur_row, cur_col + 3'd1);
    end
  end

  // The square under the pre-update cursor decides what a center press does.
  assign cur_sq  = get_square(BOARD, CURSOR_ADDR);
  assign cur_own = (cur_sq.piece != PIECE_NONE) && (cur_sq.colour == TURN);

  // Next-state and control decode. Center presses are ignored after a king
  // has been captured and dropped while a commit is in progress.
  always_comb begin
    state_next = state;
    load_sel   = 1'b0;
    clear_sel  = 1'b0;
    latch_dst  = 1'b0;
    do_commit  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (press_center && !GAME_OVER && cur_own) begin
          load_sel   = 1'b1;
          state_next = ST_SELECTED;
        end
      end
      ST_SELECTED: begin
        if (GAME_OVER) begin
          clear_sel  = 1'b1;
          state_next = ST_IDLE;
        end else if (press_center) begin
          if (CURSOR_ADDR == SELECT_ADDR) begin
            clear_sel  = 1'b1;
            state_next = ST_IDLE;
          end else if (cur_own) begin
            load_sel = 1'b1;
          end else begin
            latch_dst  = 1'b1;
            state_next = ST_COMMIT;
          end
        end
      end
      ST_COMMIT: begin
        do_commit  = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Cursor, selection, destination and game status registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      CURSOR_ADDR <= CURSOR_INIT;
      SELECT_ADDR <= 6'd0;
      SELECT_EN   <= 1'b0;
      dst_addr    <= 6'd0;
      TURN        <= COLOR_WHITE;
      MOVE_DONE   <= 1'b0;
      GAME_OVER   <= 1'b0;
    end else begin
      CURSOR_ADDR <= cursor_next;
      MOVE_DONE   <= 1'b0;
      if (load_sel) begin
        SELECT_ADDR <= CURSOR_ADDR;
        SELECT_EN   <= 1'b1;
      end
      if (clear_sel) begin
        SELECT_EN <= 1'b0;
      end
      if (latch_dst) begin
        dst_addr <= CURSOR_ADDR;
      end
      if (do_commit) begin
        TURN      <= ~TURN;
        SELECT_EN <= 1'b0;
        MOVE_DONE <= 1'b1;
        if (get_square(BOARD, dst_addr).piece == PIECE_KING) begin
          GAME_OVER <= 1'b1;
        end
      end
    end
  end

  // Board storage. A commit copies the source nibble over the destination
  // and empties the source; the destination can never equal the source
  // because pressing center on the selected square deselects instead.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      BOARD <= INIT_BOARD;
    end else if (do_commit) begin
      BOARD[{dst_addr, 2'b00} +: 4]    <= BOARD[{SELECT_ADDR, 2'b00} +: 4];
      BOARD[{SELECT_ADDR, 2'b00} +: 4] <= 4'h0;
    end
  end

endmodule
